lsu_ctrl: RTL and testbench

- Execute/memory-stage load-store unit that sits directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data and funct3 from the pipeline.
- Runs one word-aligned data-memory transaction per request over a req/ack handshake.
- Returns aligned, sign- or zero-extended load data, or a completion/error status, to the writeback stage.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_ctrl.sv | 139 +++++++++++++
 tb/tb_lsu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store funct3 codes, LSU state enum and request decode helpers
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RESP     = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        return ok;
    endfunction

    // funct3[1:0] encodes access size for every legal code; illegal codes are rejected separately
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword of a read word and extends it
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: one word-aligned memory transaction per pipeline request
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_bmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    lsu_state_e       state;
    logic             is_store_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             bad_req;
    logic [3:0]       st_bmask;
    logic [31:0]      st_wdata;
    logic [31:0]      load_data;

    lsu_load_align u_align (
        .rdata  (i_mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_data)
    );

    assign bad_req  = !f3_legal(i_is_store, i_funct3) || f3_misaligned(i_funct3, i_addr[1:0]);
    assign cnt_next = cnt + 1'b1;

    // Replicate store data across lanes so the memory only needs the byte mask
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                st_wdata = {4{i_wdata[7:0]}};
                st_bmask = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{i_wdata[15:0]}};
                st_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = i_wdata;
                st_bmask = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_req_ready  <= 1'b1;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= 32'd0;
            o_mem_bmask  <= 4'd0;
            o_mem_wdata  <= 32'd0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= 32'd0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            is_store_q   <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        is_store_q  <= i_is_store;
                        f3_q        <= i_funct3;
                        off_q       <= i_addr[1:0];
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_we    <= i_is_store;
                        o_mem_bmask <= i_is_store ? st_bmask : 4'b1111;
                        o_mem_wdata <= st_wdata;
                        cnt         <= '0;
                        o_req_ready <= 1'b0;
                        if (bad_req) begin
                            state        <= RESP;
                            o_rsp_valid  <= 1'b1;
                            o_misaligned <= 1'b1;
                            o_rsp_rdata  <= 32'd0;
                        end else begin
                            state     <= WAIT_ACK;
                            o_mem_req <= 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    // An ack on the threshold cycle wins over the timeout
                    if (i_mem_ack) begin
                        state       <= RESP;
                        o_mem_req   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= is_store_q ? 32'd0 : load_data;
                    end else if (TIMEOUT_CYC != 0 && cnt_next == CNT_W'(TIMEOUT_CYC)) begin
                        state       <= RESP;
                        o_mem_req   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_bus_err   <= 1'b1;
                        o_rsp_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    o_rsp_valid  <= 1'b0;
                    o_rsp_rdata  <= 32'd0;
                    o_misaligned <= 1'b0;
                    o_bus_err    <= 1'b0;
                    o_req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with directed and random load/store traffic
module tb_lsu_ctrl;

    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_bmask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_misaligned;
    logic        o_bus_err;

    lsu_ctrl #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_bmask  (o_mem_bmask),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_bad(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        int size;
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(lo) % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(lo));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_bmask(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        if (!st || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd1) return 4'(3 << lo);
        return 4'(1 << lo);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    always @(negedge i_clk) begin
        if (o_rsp_valid) begin
            chk("flags_exclusive", 32'(o_misaligned & o_bus_err), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_rdata", o_rsp_rdata, e.rdata);
                chk("rsp_misaligned", 32'(o_misaligned), 32'(e.mis));
                chk("rsp_bus_err", 32'(o_bus_err), 32'(e.berr));
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 20 && !o_req_ready; k++) @(negedge i_clk);
        chk("req_ready", 32'(o_req_ready), 32'd1);
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] rd);
        exp_t e;
        bit   bad;
        int   n;
        wait_ready();
        n   = cyc;
        bad = model_bad(st, f3, a[1:0]);
        e.mis   = bad;
        e.berr  = !bad && (d >= T);
        e.rdata = (bad || st || d >= T) ? 32'd0 : model_load(f3, a[1:0], rd);
        e.cyc   = bad ? n + 1 : (d >= T ? n + T + 1 : n + 2 + d);
        exp_q.push_back(e);
        i_req_valid = 1'b1;
        i_is_store  = st;
        i_funct3    = f3;
        i_addr      = a;
        i_wdata     = wd;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_addr      = $urandom;
        i_wdata     = $urandom;
        if (bad) begin
            chk("no_mem_req", 32'(o_mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= T; i++) begin
                if (i == T) begin
                    chk("timeout_drop", 32'(o_mem_req), 32'd0);
                    break;
                end
                chk("mem_req", 32'(o_mem_req), 32'd1);
                chk("mem_addr", o_mem_addr, {a[31:2], 2'b00});
                chk("mem_we", 32'(o_mem_we), 32'(st));
                chk("mem_bmask", 32'(o_mem_bmask), 32'(model_bmask(st, f3, a[1:0])));
                if (st) chk("mem_wdata", o_mem_wdata, model_wdata(f3, wd));
                if (i == d) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rd;
                    @(negedge i_clk);
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = $urandom;
                    break;
                end
                @(negedge i_clk);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_outputs", o_mem_addr | o_mem_wdata | o_rsp_rdata |
            32'({o_mem_we, o_mem_bmask, o_misaligned, o_bus_err}), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        do_req(1'b0, 3'd2, 32'h0000_1004, 32'd0, 0, 32'hDEAD_BEEF);
        do_req(1'b0, 3'd0, 32'h0000_1003, 32'd0, 1, 32'h80FF_0000);
        do_req(1'b0, 3'd4, 32'h0000_1003, 32'd0, 0, 32'h80FF_0000);
        do_req(1'b1, 3'd0, 32'h0000_2002, 32'h1234_56AB, 2, 32'hFFFF_FFFF);
        do_req(1'b0, 3'd1, 32'h0000_3001, 32'd0, 0, 32'h1111_1111);
        do_req(1'b1, 3'd2, 32'h0000_3002, 32'h5555_5555, 0, 32'd0);
        do_req(1'b0, 3'd3, 32'h0000_3000, 32'd0, 0, 32'd0);
        do_req(1'b0, 3'd2, 32'h0000_4000, 32'd0, 99, 32'h1234_5678);
        do_req(1'b0, 3'd5, 32'h0000_4002, 32'd0, T - 1, 32'hBEEF_8001);

        // reset while a load is outstanding: no response may follow
        wait_ready();
        i_req_valid = 1'b1;
        i_is_store  = 1'b0;
        i_funct3    = 3'd2;
        i_addr      = 32'h0000_5000;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rst_mid_mem_req_before", 32'(o_mem_req), 32'd1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("rst_mid_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_mid_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        chk("stray_ack_rsp", 32'(o_rsp_valid), 32'd0);
        chk("stray_ack_mem_req", 32'(o_mem_req), 32'd0);

        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = $urandom;
                @(negedge i_clk);
                i_mem_ack = 1'b0;
            end
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, int'($urandom_range(0, 5)), $urandom);
        end

        repeat (4) @(negedge i_clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
